// File: rtl/sobel_frame_packer.sv
// sobel_frame_packer: packs the Sobel filter's 8-bit pixel stream into
// PIX_PER_WORD_P-byte words with byte keep and end-of-frame marking.
// Optional frame-length policing is enabled by defining SOBEL_PACKER_CHECK_EN.
module sobel_frame_packer #(
  parameter int WIDTH_P        = 10,
  parameter int HEIGHT_P       = 10,
  parameter int PIX_PER_WORD_P = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [7:0]                  pixel_i,
  input  logic                        last_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [8*PIX_PER_WORD_P-1:0] data_o,
  output logic [PIX_PER_WORD_P-1:0]   keep_o,
  output logic                        last_o,
  output logic                        frame_done_o,
  output logic                        err_o
);

  localparam int PPW       = PIX_PER_WORD_P;
  localparam int CNT_W     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int FRAME_PIX = WIDTH_P * HEIGHT_P;
  localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PPW - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [8*PPW-1:0] acc_data_r;
  logic [PPW-1:0]   acc_keep_r;

  logic             accept;
  logic             frame_end;
  logic             word_done;
  logic [8*PPW-1:0] word_data;
  logic [PPW-1:0]   word_keep;

  // A new pixel can enter whenever the output slot is free or draining this cycle.
  assign ready_o   = ~valid_o | ready_i;
  assign accept    = valid_i & ready_o;
  assign word_done = accept & ((cnt_r == CNT_MAX) | frame_end);

  // Merge the incoming pixel into lane cnt_r of the partial word.
  genvar gi;
  generate
    for (gi = 0; gi < PPW; gi++) begin : g_lane
      assign word_data[8*gi +: 8] = (cnt_r == CNT_W'(gi)) ? pixel_i : acc_data_r[8*gi +: 8];
      assign word_keep[gi]        = (cnt_r == CNT_W'(gi)) | acc_keep_r[gi];
    end
  endgenerate

`ifdef SOBEL_PACKER_CHECK_EN
  typedef enum logic {RUN_S = 1'b0} state_t;

  state_t           state_r;
  logic [PIX_W-1:0] pix_cnt_r;
  logic             err_r;
  logic             pix_at_end;

  assign pix_at_end = (pix_cnt_r == PIX_W'(FRAME_PIX - 1));
  // The frame closes on last_i or, if last_i never comes, on the expected count.
  assign frame_end  = last_i | pix_at_end;
  assign err_o      = err_r;

  // Frame length tracking; any disagreement between last_i and the count is sticky.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r   <= RUN_S;
      pix_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        RUN_S: begin
          if (accept) begin
            pix_cnt_r <= frame_end ? '0 : pix_cnt_r + PIX_W'(1);
            if (last_i != pix_at_end) err_r <= 1'b1;
          end
        end
        default: state_r <= RUN_S;
      endcase
    end
  end
`else
  assign frame_end = last_i;
  assign err_o     = 1'b0;
`endif

  // Accumulator: collect pixels until a word completes, then start clean at lane 0.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_r      <= '0;
      acc_data_r <= '0;
      acc_keep_r <= '0;
    end else if (accept) begin
      if (word_done) begin
        cnt_r      <= '0;
        acc_data_r <= '0;
        acc_keep_r <= '0;
      end else begin
        cnt_r      <= cnt_r + CNT_W'(1);
        acc_data_r <= word_data;
        acc_keep_r <= word_keep;
      end
    end
  end

  // Output register: load on completion (even during a handshake), drop on handshake alone.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
    end else if (word_done) begin
      valid_o <= 1'b1;
      data_o  <= word_data;
      keep_o  <= word_keep;
      last_o  <= frame_end;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  assign frame_done_o = valid_o & ready_i & last_o;

endmodule

// File: tb/tb_sobel_frame_packer.sv
// Directed bench for sobel_frame_packer (WIDTH_P=4, HEIGHT_P=2, 4 pixels/word).
// Expectations adapt to whether SOBEL_PACKER_CHECK_EN is defined.
module tb_sobel_frame_packer;

  logic        clk_i;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  pixel_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        frame_done_o;
  logic        err_o;

  int n_run;
  int n_fail;
  int done_cnt;
  logic [36:0] wq[$];

  sobel_frame_packer #(
    .WIDTH_P(4),
    .HEIGHT_P(2),
    .PIX_PER_WORD_P(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .pixel_i(pixel_i),
    .last_i(last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o(data_o),
    .keep_o(keep_o),
    .last_o(last_o),
    .frame_done_o(frame_done_o),
    .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Record every output handshake as {last, keep, data}.
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (valid_o && ready_i) begin
        wq.push_back({last_o, keep_o, data_o});
        $display("[TB] word data=%08h keep=%h last=%0d", data_o, keep_o, last_o);
      end
      if (frame_done_o) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    pixel_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] p, input logic l);
    bit acc;
    valid_i = 1'b1;
    pixel_i = p;
    last_i  = l;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    n_run++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout pixel=%02h got ready_o=0 for 50 cycles, required accept", p);
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    pixel_i = 8'h00;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_run++;
    if ({valid_o, data_o, keep_o, last_o, frame_done_o, err_o} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h k=%h l=%b fd=%b e=%b, required all 0",
               valid_o, data_o, keep_o, last_o, frame_done_o, err_o);
    end
    n_run++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b, required 1", ready_o);
    end
    reset_i = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_full_frame();
    logic [36:0] exp[$];
    do_reset();
    ready_i = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      send(8'(p), p == 8);
      if (p == 3) begin
        n_run++;
        if (valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early_valid got %b, required 0", valid_o);
        end
      end
      if (p == 4) begin
        n_run++;
        if ({valid_o, last_o, keep_o, data_o} !== {1'b1, 1'b0, 4'hF, 32'h04030201}) begin
          n_fail++;
          $display("FAIL full_latency_w0 got v=%b l=%b k=%h d=%h, required 1 0 f 04030201",
                   valid_o, last_o, keep_o, data_o);
        end
      end
      if (p == 8) begin
        n_run++;
        if ({valid_o, last_o, keep_o, data_o} !== {1'b1, 1'b1, 4'hF, 32'h08070605}) begin
          n_fail++;
          $display("FAIL full_latency_w1 got v=%b l=%b k=%h d=%h, required 1 1 f 08070605",
                   valid_o, last_o, keep_o, data_o);
        end
      end
    end
    idle(3);
    exp.push_back({1'b0, 4'hF, 32'h04030201});
    exp.push_back({1'b1, 4'hF, 32'h08070605});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL full_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL full_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    n_run++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL full_frame_done got %0d pulses, required 1", done_cnt);
    end
    n_run++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_err got %b, required 0", err_o);
    end
    $display("[TB] test_full_frame done");
  endtask

  task automatic test_backpressure();
    logic [36:0] exp[$];
    do_reset();
    ready_i = 1'b0;
    for (int p = 1; p <= 4; p++) send(8'(p), 1'b0);
    valid_i = 1'b1;
    pixel_i = 8'h05;
    last_i  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      n_run++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 32'h04030201) begin
        n_fail++;
        $display("FAIL stall_cycle%0d got ready_o=%b valid_o=%b data=%h, required 0 1 04030201",
                 c, ready_o, valid_o, data_o);
      end
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b1;
    for (int p = 5; p <= 8; p++) send(8'(p), p == 8);
    idle(3);
    exp.push_back({1'b0, 4'hF, 32'h04030201});
    exp.push_back({1'b1, 4'hF, 32'h08070605});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL bp_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    n_run++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_frame_done got %0d pulses, required 1", done_cnt);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp[$];
    do_reset();
    ready_i = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int p = 1; p <= 8; p++) send(8'(f * 16 + p), p == 8);
    idle(3);
    exp.push_back({1'b0, 4'hF, 32'h04030201});
    exp.push_back({1'b1, 4'hF, 32'h08070605});
    exp.push_back({1'b0, 4'hF, 32'h14131211});
    exp.push_back({1'b1, 4'hF, 32'h18171615});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL b2b_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    n_run++;
    if (done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_frame_done got %0d pulses, required 2", done_cnt);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_early_last();
    logic [36:0] exp[$];
    logic exp_err;
`ifdef SOBEL_PACKER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    ready_i = 1'b1;
    for (int p = 1; p <= 6; p++) send(8'(p), p == 6);
    n_run++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL early_err got %b, required %b", err_o, exp_err);
    end
    for (int p = 1; p <= 8; p++) send(8'(8'h20 + p), p == 8);
    idle(3);
    n_run++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL early_err_sticky got %b, required %b", err_o, exp_err);
    end
    exp.push_back({1'b0, 4'hF, 32'h04030201});
    exp.push_back({1'b1, 4'h3, 32'h00000605});
    exp.push_back({1'b0, 4'hF, 32'h24232221});
    exp.push_back({1'b1, 4'hF, 32'h28272625});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL early_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL early_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    $display("[TB] test_early_last done");
  endtask

  task automatic test_missing_last();
    logic [36:0] exp[$];
    logic exp_err;
    int   exp_done;
    do_reset();
    ready_i = 1'b1;
    for (int p = 1; p <= 8; p++) send(8'(p), 1'b0);
    send(8'h09, 1'b1);
    idle(3);
    exp.push_back({1'b0, 4'hF, 32'h04030201});
`ifdef SOBEL_PACKER_CHECK_EN
    exp.push_back({1'b1, 4'hF, 32'h08070605});
    exp_err  = 1'b1;
    exp_done = 2;
`else
    exp.push_back({1'b0, 4'hF, 32'h08070605});
    exp_err  = 1'b0;
    exp_done = 1;
`endif
    exp.push_back({1'b1, 4'h1, 32'h00000009});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL missing_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL missing_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    n_run++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL missing_err got %b, required %b", err_o, exp_err);
    end
    n_run++;
    if (done_cnt != exp_done) begin
      n_fail++;
      $display("FAIL missing_frame_done got %0d pulses, required %0d", done_cnt, exp_done);
    end
    $display("[TB] test_missing_last done");
  endtask

  task automatic test_reset_mid();
    logic [36:0] exp[$];
    // Leave a complete word pending under backpressure, then reset.
    ready_i = 1'b0;
    for (int p = 1; p <= 4; p++) send(8'(8'h40 + p), 1'b0);
    valid_i = 1'b0;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_run++;
    if ({valid_o, data_o, keep_o, last_o, frame_done_o, err_o, ready_o} !== {39'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_outputs got v=%b d=%h k=%h l=%b fd=%b e=%b r=%b, required zeros, ready 1",
               valid_o, data_o, keep_o, last_o, frame_done_o, err_o, ready_o);
    end
    reset_i = 1'b1;
    ready_i = 1'b1;
    // Three pixels of a partial word, then reset again.
    for (int p = 1; p <= 3; p++) send(8'(8'h30 + p), 1'b0);
    valid_i = 1'b0;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    wq.delete();
    done_cnt = 0;
    for (int p = 1; p <= 8; p++) send(8'(8'h10 + p), p == 8);
    idle(3);
    exp.push_back({1'b0, 4'hF, 32'h14131211});
    exp.push_back({1'b1, 4'hF, 32'h18171615});
    n_run++;
    if (wq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL midreset_count got %0d words, required %0d", wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_run++;
      if (wq[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL midreset_word%0d got %h, required %h", i, wq[i], exp[i]);
      end
    end
    n_run++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_err got %b, required 0", err_o);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    done_cnt = 0;
    reset_i  = 1'b0;
    valid_i  = 1'b0;
    last_i   = 1'b0;
    pixel_i  = 8'h00;
    ready_i  = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_frame_packer.md
# sobel_frame_packer

Output-side receiver for the per-channel Sobel filter stream. It accepts the filter's 8-bit pixel stream (valid/ready, with a `last` flag on the final pixel of a frame). It packs `PIX_PER_WORD_P` pixels into one wide word for the downstream frame writer, with byte-keep and end-of-frame marking. It also polices frame length against the configured image size.

## Interface
- `WIDTH_P`, 10, image width in pixels.
- `HEIGHT_P`, 10, image height in pixels.
- `PIX_PER_WORD_P`, 4, pixels per output word; legal values are 1, 2, 4 and 8.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, synchronous, active-low.
- `valid_i` in 1: input pixel valid.
- `ready_o` out 1: input pixel accepted when high with `valid_i`.
- `pixel_i` in 8: filtered pixel.
- `last_i` in 1: marks the final pixel of a frame.
- `valid_o` out 1: output word valid.
- `ready_i` in 1: downstream accepts the word.
- `data_o` out 8*`PIX_PER_WORD_P`: packed pixels, with the first pixel in the least-significant byte.
- `keep_o` out `PIX_PER_WORD_P`: one bit per valid byte of `data_o`.
- `last_o` out 1: the word closes a frame.
- `frame_done_o` out 1: one-cycle pulse when a `last_o` word handshakes.
- `err_o` out 1: sticky frame-length error.

## Operation
**Datapath**
- Accumulator register holds the partial word, its byte count `cnt_r` (range 0..`PIX_PER_WORD_P`-1) and the keep bits.
- Output register holds one complete word: `valid_o`, `data_o`, `keep_o` and `last_o`.
- Input accept: `ready_o = ~valid_o | ready_i` (combinational). A pixel is accepted when `valid_i & ready_o`.
- On accept, the pixel is written into byte lane `cnt_r` and `keep[cnt_r]` is set.

**Word completion**
- A word completes when `cnt_r == PIX_PER_WORD_P-1` or the accepted pixel ends the frame.
- On completion, the word (including the new pixel) loads the output register in the same edge.
- `last_o` is set if the pixel ends the frame. The accumulator clears to `cnt_r = 0` with zero data and zero keep.
- A partial final word is zero-padded in its unused lanes, and their keep bits stay 0.

**Output handshake**
- The output word is held stable while `valid_o & ~ready_i`.
- A handshake combined with a simultaneous completion reloads the output register; there is no bubble.
- A handshake without a completion clears `valid_o`.

**Frame state machine** (only with the check feature; see Configuration)
- State `RUN_S` only, with pixel counter `pix_cnt_r` ranging 0..`WIDTH_P*HEIGHT_P`-1.
- A pixel ends the frame when `last_i` is high or `pix_cnt_r == WIDTH_P*HEIGHT_P-1`.
- On frame end, `pix_cnt_r` returns to 0.
- `err_o` sets on either mismatch:
  - `last_i` arrives with `pix_cnt_r` not equal to `WIDTH_P*HEIGHT_P-1` (early last).
  - The count reaches `WIDTH_P*HEIGHT_P-1` without `last_i` (missing last; the frame is forced closed).
- `err_o` clears only on reset.

**Other rules**
- `frame_done_o` pulses in the cycle of a `valid_o & ready_i & last_o` handshake.
- Arithmetic: `pix_cnt_r` width is `$clog2(WIDTH_P*HEIGHT_P)`; `cnt_r` width is `$clog2(PIX_PER_WORD_P)`, minimum 1.
- When `PIX_PER_WORD_P == 1`, every accepted pixel completes a word.

## Timing
- **Reset values** (`reset_i` low at a rising edge): `valid_o`=0, `data_o`=0, `keep_o`=0, `last_o`=0, `frame_done_o`=0, `err_o`=0, `cnt_r`=0, `pix_cnt_r`=0.
- `ready_o` is 1 out of reset.
- **Latency:** a pixel completing a word at edge t gives `valid_o`=1 in cycle t+1.
- **Throughput:** one pixel per cycle when `ready_i` is held high.
- **Backpressure:** with `valid_o` high and `ready_i` low, `ready_o` drops in the same cycle. The partially filled accumulator is held, and no pixel is lost or duplicated.
- **Reset mid-frame:** all partial words, pending output and counters are discarded, and the next accepted pixel starts frame pixel 0, lane 0.
- **Back-to-back frames:** the first pixel of the next frame may be accepted in the cycle after the previous frame's last pixel. It lands in lane 0 of a new word.

## Configuration
- Macro `SOBEL_PACKER_CHECK_EN`.
- Defined: `pix_cnt_r`, the early/missing-last detection, forced frame close and the `err_o` logic are present.
- Undefined: the counter is removed and `err_o` is tied to 0.
  - Frames end only on `last_i`; any length passes through unchanged.
  - All packing and handshake behaviour is identical.

## Test plan
(`WIDTH_P=4`, `HEIGHT_P=2`, `PIX_PER_WORD_P=4`, macro defined unless noted)
- **Full frame:** pixels 0x01..0x08 with `last_i` on 0x08 and `ready_i`=1 -> words 0x04030201 (keep 0xF, last 0), then 0x08070605 (keep 0xF, last 1). `frame_done_o` pulses once, `err_o`=0, and each word appears one cycle after its completing pixel.
- **Early last:** pixels 0x01..0x06 with `last_i` on 0x06 -> 0x04030201, then 0x00000605 (keep 0x3, last 1). `err_o`=1 stays high through the next clean frame.
- **Missing last:** eight pixels with no `last_i` -> the second word has `last_o`=1 and `err_o`=1. The ninth pixel appears in lane 0 of a new frame.
- **Backpressure:** `ready_i` low for 5 cycles after the first word completes -> `ready_o`=0 during the stall, `data_o` is stable at 0x04030201, and the resumed output sequence is exact.
- **Reset mid-frame:** reset after 3 pixels -> all outputs return to their reset values. A following clean 8-pixel frame yields exactly two correct words.
- **Macro undefined:** a 6-pixel frame with `last_i` -> words 0x04030201 and 0x00000605 (keep 0x3, last 1), with `err_o` staying 0.
